ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the single-scancode keyboard port. It deglitches and synchronises PS2CLK/PS2DATA and deframes 11-bit frames. It folds the E0 (extended) and F0 (release) prefixes into flags and queues decoded keys in a first-word-fall-through FIFO. Unlike the previous port, it reports parity, framing and timeout errors and buffers keys, so the CPU or keymap side can consume them at its own pace.

Parameters:
FILTER_LEN, 16, deglitch window in clk cycles; even, >=4
TIMEOUT_CYCLES, 65536, clk cycles without an accepted falling edge before an in-progress frame is aborted
FIFO_DEPTH, 8, key FIFO entries; power of two, >=2

Ports:
clk  in  1  system clock; 1-600 MHz
rst_n  in  1  asynchronous active-low reset
enable_rcv  in  1  1 = accept frames; 0 = falling edges ignored
ps2clk_ext  in  1  raw PS/2 clock (asynchronous)
ps2data_ext  in  1  raw PS/2 data (asynchronous)
rd_en  in  1  pop the FIFO head; ignored when empty
scancode  out  8  FIFO head code; valid when !empty
released  out  1  FIFO head release flag
extended  out  1  FIFO head extended flag
empty  out  1  FIFO empty
count  out  $clog2(FIFO_DEPTH+1)  entries held
kb_interrupt  out  1  1-cycle pulse on each FIFO push
parity_err  out  1  1-cycle pulse on a parity failure
frame_err  out  1  1-cycle pulse when the stop bit is 0
timeout_err  out  1  1-cycle pulse on a mid-frame timeout
overflow  out  1  1-cycle pulse when a key is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync deassert by design): state IDLE; FIFO empty; count=0; empty=1; scancode/released/extended=0; all pulses 0; prefix flags 0; synchronisers and filter loaded with 1s, so no false edge at release.
- Sync: 2-flop synchroniser on each input. Filter: FILTER_LEN-bit shift register of the synchronised clock. An edge is accepted when the older half is all 1s and the newer half is all 0s. This gives exactly one accept per clean falling edge; shorter glitches are never accepted.
- Bit sampling: ps2data is sampled at the accepted edge, and only when enable_rcv=1.
- FSM:
  - IDLE: data=0 -> DATA (bit count cleared); data=1 -> stay.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: if the 8 data bits plus the parity bit have odd weight -> STOP; otherwise parity_err pulse and go to IDLE.
  - STOP: always return to IDLE. data=1 -> decode the byte; data=0 -> frame_err pulse, byte discarded.
- Timeout: the counter clears on every accepted edge and in IDLE, and increments otherwise. On reaching TIMEOUT_CYCLES-1 outside IDLE: go to IDLE, fire timeout_err, clear the prefix flags.
- Decode:
  - E0: set ext_pend.
  - F0: set rel_pend.
  - Any other byte: push {ext_pend, rel_pend, byte}, then clear both flags.
  - Any error clears both flags.
  - Prefix bytes never push and never pulse kb_interrupt.
- FIFO: FWFT, so the head appears on the outputs the cycle after the push into an empty FIFO.
  - rd_en with !empty pops; the next entry (or empty=1) appears the following cycle.
  - Push and pop in the same cycle while full: both happen, no overflow, count unchanged.
  - Push while full without a pop: entry dropped, overflow pulse, FIFO contents unchanged, kb_interrupt not asserted.
  - Pointers wrap modulo FIFO_DEPTH.
- kb_interrupt is asserted in the cycle after the stop-bit edge, together with the count increment.
- enable_rcv falling mid-frame: the FSM freezes and the timeout still runs, so the frame is aborted with timeout_err unless enable_rcv returns first.

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> one kb_interrupt; scancode=0x1C, released=0, extended=0, count=1; rd_en -> empty=1.
- Frames E0, F0, 75 -> exactly one push: scancode=0x75, extended=1, released=1. A following frame 0x75 pushes with both flags 0.
- Frame 0x1C with parity 1 -> parity_err pulse, count stays 0. A frame 0x1C with stop bit 0 -> frame_err pulse, no push.
- FIFO_DEPTH=8: send 9 keys 0x01..0x09 with no reads -> count=8 and overflow pulse on the 9th. Reading 8 times yields 0x01..0x08; push and pop in the same cycle while full produces no overflow.
- ps2clk low pulses of FILTER_LEN/2-1 cycles -> no edge accepted, no pulses. A frame stalled after 4 bits for TIMEOUT_CYCLES -> timeout_err. A subsequent clean 0x2A is received correctly.
- rst_n asserted mid-frame with 3 entries queued -> empty=1 and count=0 immediately; the next complete frame is received normally.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with input deglitching, E0/F0 prefix folding,
// error reporting and a first-word-fall-through key FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable_rcv,
  input  logic                              ps2clk_ext,
  input  logic                              ps2data_ext,
  input  logic                              rd_en,
  output logic [7:0]                        scancode,
  output logic                              released,
  output logic                              extended,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              kb_interrupt,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              timeout_err,
  output logic                              overflow
);

  localparam int HALF  = FILTER_LEN / 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic                  clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic [FILTER_LEN-1:0] filt_q;
  state_t                state_q, state_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  ext_q, ext_d, rel_q, rel_d;
  logic [7:0]            shift_q;
  logic                  shift_en, push_req;
  logic                  kbi_q, kbi_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  terr_q, terr_d, ovf_q, ovf_d;
  logic [9:0]            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  edge_det, acc, full, empty_w, pop, wr_ok;
  logic [9:0]            head;

  // A clean falling edge shows as an all-ones older half and all-zeros newer half.
  assign edge_det = (&filt_q[FILTER_LEN-1:HALF]) && !(|filt_q[HALF-1:0]);
  assign acc      = edge_det && enable_rcv;

  // Synchronisers and deglitch filter idle high so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      filt_q    <= '1;
    end else begin
      clk_s1_q  <= ps2clk_ext;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2data_ext;
      data_s2_q <= data_s1_q;
      filt_q    <= {filt_q[FILTER_LEN-2:0], clk_s2_q};
    end
  end

  // Frame deserialiser, timeout watchdog and prefix decoding.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    to_cnt_d = to_cnt_q;
    ext_d    = ext_q;
    rel_d    = rel_q;
    shift_en = 1'b0;
    push_req = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    terr_d   = 1'b0;
    if (state_q == S_IDLE || acc) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      state_d  = S_IDLE;
      terr_d   = 1'b1;
      ext_d    = 1'b0;
      rel_d    = 1'b0;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (acc) begin
      case (state_q)
        S_IDLE: begin
          if (!data_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shift_en = 1'b1;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          if (^{shift_q, data_s2_q}) begin
            state_d = S_STOP;
          end else begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
          end
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!data_s2_q) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            rel_d = 1'b1;
          end else begin
            push_req = 1'b1;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Receiver control state and error/event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      to_cnt_q <= '0;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      kbi_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      terr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      to_cnt_q <= to_cnt_d;
      ext_q    <= ext_d;
      rel_q    <= rel_d;
      kbi_q    <= kbi_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      terr_q   <= terr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Data bits arrive LSB first.
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {data_s2_q, shift_q[7:1]};
  end

  assign full    = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);
  assign pop     = rd_en && !empty_w;
  assign wr_ok   = push_req && (!full || pop);
  assign ovf_d   = push_req && full && !pop;
  assign kbi_d   = wr_ok;

  // Occupancy follows push and pop together; simultaneous ones cancel.
  always_comb begin
    count_d = count_q;
    if (wr_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_ok) count_d = count_q - 1'b1;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Key storage: {extended, released, code}.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= {ext_q, rel_q, shift_q};
  end

  assign head         = mem_q[rd_ptr_q];
  assign scancode     = empty_w ? 8'h00 : head[7:0];
  assign released     = empty_w ? 1'b0  : head[8];
  assign extended     = empty_w ? 1'b0  : head[9];
  assign empty        = empty_w;
  assign count        = count_q;
  assign kb_interrupt = kbi_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign timeout_err  = terr_q;
  assign overflow     = ovf_q;

endmodule
